// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Bundles the decode-side request and the issue/writeback response of the
//   hazard scoreboard so the decoder and the scoreboard share one port.
//
//   master : decoder side, drives id_* and flush, observes every result.
//   slave  : scoreboard side, observes id_* and flush, drives every result.
//
//   Request  : id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
//              id_reg_write, flush
//   Response : pc_write, issue, raw_hazard, rs1_hazard, rs2_hazard,
//              fwd_rs1, fwd_rs2, wb_valid, wb_rd, stall_count, hazard_err
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic [REG_ADDR_W-1:0]  id_rd;
  logic                   id_reg_write;
  logic                   flush;

  logic                   pc_write;
  logic                   issue;
  logic                   raw_hazard;
  logic                   rs1_hazard;
  logic                   rs2_hazard;
  logic                   fwd_rs1;
  logic                   fwd_rs2;
  logic                   wb_valid;
  logic [REG_ADDR_W-1:0]  wb_rd;
  logic [STALL_CNT_W-1:0] stall_count;
  logic                   hazard_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, flush,
    input  pc_write, issue, raw_hazard, rs1_hazard, rs2_hazard, fwd_rs1,
           fwd_rs2, wb_valid, wb_rd, stall_count, hazard_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, flush,
    output pc_write, issue, raw_hazard, rs1_hazard, rs2_hazard, fwd_rs1,
           fwd_rs2, wb_valid, wb_rd, stall_count, hazard_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Issue controller for the single-issue cpu core. Keeps a shift register
//   of the destination registers of in-flight instructions, compares them
//   against the sources of the decoded instruction, and stalls (pc_write=0,
//   bubble inserted) while a RAW dependency is pending. The oldest stage is
//   the writeback stage and qualifies register-file writes.
//
//   Parameters : WB_LATENCY (1..4) stages from issue to writeback,
//                REG_ADDR_W register address width,
//                STALL_CNT_W width of the saturating stall counter.
//   Ports      : clock  - rising-edge clock
//                reset  - synchronous, active-high
//                bus    - hazard_scoreboard_if.slave (decode request in,
//                         issue / hazard / writeback / statistics out)
//
//   Optional feature: define HAZARD_FORWARD_EN to let an operand whose only
//   matching producer sits in the writeback stage be forwarded from the
//   writeback bus instead of stalling (fwd_rs1/fwd_rs2 flag it). Without
//   the macro every match stalls and fwd_rs1/fwd_rs2 are tied to 0.
module hazard_scoreboard #(
  parameter int WB_LATENCY  = 2,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  hazard_scoreboard_if.slave bus
);
  localparam int WB_STAGE = WB_LATENCY - 1;
  // Run counter needs to reach WB_LATENCY+1 so the overrun is visible;
  // it then holds instead of wrapping.
  localparam int RUN_W = $clog2(WB_LATENCY + 2);
  localparam logic [RUN_W-1:0]       RUN_MAX   = RUN_W'(WB_LATENCY + 1);
  localparam logic [RUN_W-1:0]       RUN_LIMIT = RUN_W'(WB_LATENCY);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  logic [WB_LATENCY-1:0]  stage_v;
  logic [REG_ADDR_W-1:0]  stage_rd [WB_LATENCY];
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [RUN_W-1:0]       run_cnt;
  logic                   err_flag;

  logic rs1_young, rs1_wb, rs2_young, rs2_wb;
  logic rs1_haz, rs2_haz, fwd1, fwd2;
  logic stall, issue_now, load_entry;

  // Split matches into "writeback stage" and "any younger stage" so the
  // forwarding build can ignore a match that lives only in writeback.
  always_comb begin
    rs1_young = 1'b0;
    rs1_wb    = 1'b0;
    rs2_young = 1'b0;
    rs2_wb    = 1'b0;
    for (int k = 0; k < WB_LATENCY; k++) begin
      if (stage_v[k] && bus.id_uses_rs1 && (bus.id_rs1 != '0) &&
          (stage_rd[k] == bus.id_rs1)) begin
        if (k == WB_STAGE) rs1_wb = 1'b1;
        else               rs1_young = 1'b1;
      end
      if (stage_v[k] && bus.id_uses_rs2 && (bus.id_rs2 != '0) &&
          (stage_rd[k] == bus.id_rs2)) begin
        if (k == WB_STAGE) rs2_wb = 1'b1;
        else               rs2_young = 1'b1;
      end
    end
  end

  // Hazards and forwarding are forced low while reset is held.
  always_comb begin
    rs1_haz = 1'b0;
    rs2_haz = 1'b0;
    fwd1    = 1'b0;
    fwd2    = 1'b0;
    if (bus.id_valid && !reset) begin
`ifdef HAZARD_FORWARD_EN
      rs1_haz = rs1_young;
      rs2_haz = rs2_young;
      fwd1    = rs1_wb && !rs1_young;
      fwd2    = rs2_wb && !rs2_young;
`else
      rs1_haz = rs1_young || rs1_wb;
      rs2_haz = rs2_young || rs2_wb;
`endif
    end
  end

  // A flush wins over a stall: the PC moves and a bubble goes in.
  always_comb begin
    stall      = bus.id_valid && (rs1_haz || rs2_haz) && !bus.flush;
    issue_now  = bus.id_valid && !(rs1_haz || rs2_haz) && !bus.flush && !reset;
    load_entry = issue_now && bus.id_reg_write && (bus.id_rd != '0);
  end

  // Pipeline shift, stall statistics and the stall-run overrun check.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_v <= '0;
      for (int k = 0; k < WB_LATENCY; k++) stage_rd[k] <= '0;
      stall_cnt <= '0;
      run_cnt   <= '0;
      err_flag  <= 1'b0;
    end else begin
      for (int k = 1; k < WB_LATENCY; k++) begin
        stage_v[k]  <= stage_v[k-1];
        stage_rd[k] <= stage_rd[k-1];
      end
      stage_v[0]  <= load_entry;
      stage_rd[0] <= load_entry ? bus.id_rd : '0;
      if (stall) begin
        if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
        if (run_cnt != RUN_MAX)     run_cnt   <= run_cnt + 1'b1;
        // This stall makes the run one longer than WB_LATENCY.
        if (run_cnt >= RUN_LIMIT)   err_flag  <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

  assign bus.rs1_hazard  = rs1_haz;
  assign bus.rs2_hazard  = rs2_haz;
  assign bus.raw_hazard  = rs1_haz || rs2_haz;
  assign bus.fwd_rs1     = fwd1;
  assign bus.fwd_rs2     = fwd2;
  assign bus.issue       = issue_now;
  assign bus.pc_write    = !reset && !stall;
  assign bus.wb_valid    = stage_v[WB_STAGE];
  assign bus.wb_rd       = stage_rd[WB_STAGE];
  assign bus.stall_count = stall_cnt;
  assign bus.hazard_err  = err_flag;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Drives directed instruction sequences followed by random traffic into
//   hazard_scoreboard. A reference model tracks issued producers by issue
//   cycle and derives stalls from producer age; expected responses are
//   queued and a separate monitor compares them against the DUT.
module tb_hazard_scoreboard;
  localparam int L  = 2;
  localparam int AW = 5;
  localparam int SW = 4;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic          valid;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          rw;
  } instr_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] rd;
  } prod_t;

  typedef struct {
    int            cyc;
    logic          chk_reg;
    logic          pc_write, issue, raw, rs1h, rs2h, f1, f2, wbv, err;
    logic [AW-1:0] wbrd;
    logic [SW-1:0] sc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_scoreboard_if #(.REG_ADDR_W(AW), .STALL_CNT_W(SW)) bus ();

  hazard_scoreboard #(.WB_LATENCY(L), .REG_ADDR_W(AW), .STALL_CNT_W(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t  exp_q[$];
  prod_t inflight[$];
  int    cycle     = 0;
  int    m_stall   = 0;
  int    m_run     = 0;
  bit    m_err     = 1'b0;
  bit    m_known   = 1'b0;
  int    n_checks  = 0;
  int    n_fail    = 0;

  function automatic instr_t mk(input logic v, input int rs1, input int rs2,
                                input logic u1, input logic u2,
                                input int rd, input logic rw);
    instr_t i;
    i.valid = v;  i.rs1 = AW'(rs1); i.rs2 = AW'(rs2);
    i.u1 = u1;    i.u2 = u2;        i.rd = AW'(rd);  i.rw = rw;
    return i;
  endfunction

  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL cycle %0d %s: got %0h expected %0h", cyc, name, act, exp);
    end
  endtask

  // Drive one cycle, predict the response from producer ages, queue it.
  task automatic applyStimulus(input instr_t ins, input logic fl,
                               input logic rst, output logic issued);
    exp_t e;
    logic y1, w1, y2, w2, h1, h2, st, iss;
    int   age;
    @(negedge clock);
    reset            = rst;
    bus.id_valid     = ins.valid;
    bus.id_rs1       = ins.rs1;
    bus.id_rs2       = ins.rs2;
    bus.id_uses_rs1  = ins.u1;
    bus.id_uses_rs2  = ins.u2;
    bus.id_rd        = ins.rd;
    bus.id_reg_write = ins.rw;
    bus.flush        = fl;

    while (inflight.size() > 0 && (cycle - inflight[0].cyc) > L)
      void'(inflight.pop_front());

    y1 = 0; w1 = 0; y2 = 0; w2 = 0;
    e.wbv = 0; e.wbrd = '0;
    foreach (inflight[i]) begin
      age = cycle - inflight[i].cyc;
      if (age == L) begin e.wbv = 1; e.wbrd = inflight[i].rd; end
      if (ins.u1 && ins.rs1 != 0 && inflight[i].rd == ins.rs1) begin
        if (age == L) w1 = 1; else y1 = 1;
      end
      if (ins.u2 && ins.rs2 != 0 && inflight[i].rd == ins.rs2) begin
        if (age == L) w2 = 1; else y2 = 1;
      end
    end
    h1  = !rst && ins.valid && (y1 || (w1 && !FWD));
    h2  = !rst && ins.valid && (y2 || (w2 && !FWD));
    st  = ins.valid && (h1 || h2) && !fl;
    iss = ins.valid && !(h1 || h2) && !fl && !rst;

    e.cyc = cycle;  e.chk_reg = m_known;
    e.pc_write = !rst && !st;  e.issue = iss;
    e.rs1h = h1;  e.rs2h = h2;  e.raw = h1 || h2;
    e.f1 = FWD && !rst && ins.valid && w1 && !y1;
    e.f2 = FWD && !rst && ins.valid && w2 && !y2;
    e.sc = SW'(m_stall);  e.err = m_err;
    exp_q.push_back(e);

    if (rst) begin
      inflight.delete();
      m_stall = 0; m_run = 0; m_err = 0; m_known = 1;
    end else begin
      if (iss && ins.rw && ins.rd != 0) inflight.push_back('{cycle, ins.rd});
      if (st) begin
        if (m_stall < (1 << SW) - 1) m_stall++;
        m_run++;
        if (m_run > L) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
    cycle++;
    issued = iss;
  endtask

  // Present an instruction until the model says it issued.
  task automatic sendInstr(input instr_t ins);
    logic issued;
    for (int n = 0; n < 10; n++) begin
      applyStimulus(ins, 1'b0, 1'b0, issued);
      if (issued) break;
    end
  endtask

  task automatic idle(input int n);
    logic issued;
    for (int i = 0; i < n; i++) applyStimulus(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, issued);
  endtask

  // Monitor: every cycle the DUT presents a response, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc_write",   e.cyc, 32'(bus.pc_write),   32'(e.pc_write));
        checkOutput("issue",      e.cyc, 32'(bus.issue),      32'(e.issue));
        checkOutput("raw_hazard", e.cyc, 32'(bus.raw_hazard), 32'(e.raw));
        checkOutput("rs1_hazard", e.cyc, 32'(bus.rs1_hazard), 32'(e.rs1h));
        checkOutput("rs2_hazard", e.cyc, 32'(bus.rs2_hazard), 32'(e.rs2h));
        checkOutput("fwd_rs1",    e.cyc, 32'(bus.fwd_rs1),    32'(e.f1));
        checkOutput("fwd_rs2",    e.cyc, 32'(bus.fwd_rs2),    32'(e.f2));
        if (e.chk_reg) begin
          checkOutput("wb_valid",    e.cyc, 32'(bus.wb_valid),    32'(e.wbv));
          checkOutput("wb_rd",       e.cyc, 32'(bus.wb_rd),       32'(e.wbrd));
          checkOutput("stall_count", e.cyc, 32'(bus.stall_count), 32'(e.sc));
          checkOutput("hazard_err",  e.cyc, 32'(bus.hazard_err),  32'(e.err));
        end
      end
    end
  end

  initial begin
    logic issued;
    instr_t r;
    reset = 1'b1;
    bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 0;
    bus.id_uses_rs2 = 0; bus.id_rd = '0; bus.id_reg_write = 0; bus.flush = 0;

    repeat (2) applyStimulus(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, issued);

    // Independent stream addi x1, x2, x3.
    sendInstr(mk(1, 0, 0, 1, 0, 1, 1));
    sendInstr(mk(1, 0, 0, 1, 0, 2, 1));
    sendInstr(mk(1, 0, 0, 1, 0, 3, 1));
    idle(3);

    // addi x5 then add x6,x5,x0.
    sendInstr(mk(1, 0, 0, 1, 0, 5, 1));
    sendInstr(mk(1, 5, 0, 1, 1, 6, 1));
    idle(3);

    // x0 producer/consumer and an unused rs2 matching a pending rd.
    sendInstr(mk(1, 0, 0, 1, 0, 0, 1));
    sendInstr(mk(1, 0, 0, 1, 1, 4, 1));
    sendInstr(mk(1, 0, 0, 1, 0, 9, 1));
    sendInstr(mk(1, 0, 9, 1, 0, 11, 1));
    idle(3);

    // One stall cycle, then flush the dependent instruction.
    sendInstr(mk(1, 0, 0, 1, 0, 10, 1));
    applyStimulus(mk(1, 10, 0, 1, 0, 12, 1), 1'b0, 1'b0, issued);
    applyStimulus(mk(1, 10, 0, 1, 0, 12, 1), 1'b1, 1'b0, issued);
    idle(3);

    // Reset during a stall with x7 pending, then add x8,x7,x7.
    sendInstr(mk(1, 0, 0, 1, 0, 7, 1));
    applyStimulus(mk(1, 7, 0, 1, 0, 13, 1), 1'b0, 1'b0, issued);
    applyStimulus(mk(1, 7, 0, 1, 0, 13, 1), 1'b0, 1'b1, issued);
    sendInstr(mk(1, 7, 7, 1, 1, 8, 1));
    idle(3);

    // Back-to-back dependent pairs drive the narrow counter into saturation.
    for (int i = 0; i < 9; i++) begin
      sendInstr(mk(1, 0, 0, 1, 0, 14, 1));
      sendInstr(mk(1, 0, 14, 0, 1, 15, 1));
    end
    idle(3);

    // Random traffic over a small register set to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      r = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
      applyStimulus(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0), issued);
    end

    @(negedge clock);
    #4;
    checkOutput("queue_drained", cycle, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue controller for the single-issue `cpu` core: tracks destination registers of in-flight instructions between decode and register-file writeback, detects RAW hazards against the decoded instruction, and sequences issue by gating `pc_write` and inserting bubbles. It also produces the registered writeback-stage tag that qualifies register-file writes. It sits between the decoder and the PC/register-file write enable. An optional forwarding mode removes the final stall cycle.

## Interface
- `WB_LATENCY`, 2: in-flight stages from issue to writeback, legal range 1..4.
- `REG_ADDR_W`, 5: register address width.
- `STALL_CNT_W`, 16: width of the stall statistics counter.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: decoded instruction present.
- `id_rs1`, `id_rs2` in REG_ADDR_W: source registers.
- `id_uses_rs1`, `id_uses_rs2` in 1: source actually read.
- `id_rd` in REG_ADDR_W: destination register.
- `id_reg_write` in 1: instruction writes `id_rd`.
- `flush` in 1: squash the decoded instruction (taken branch).
- `pc_write` out 1: PC may advance.
- `issue` out 1: decoded instruction issued this cycle.
- `raw_hazard`, `rs1_hazard`, `rs2_hazard` out 1: stall causes.
- `fwd_rs1`, `fwd_rs2` out 1: take operand from the writeback bus.
- `wb_valid` out 1: writeback-stage entry writes a register.
- `wb_rd` out REG_ADDR_W: writeback destination.
- `stall_count` out STALL_CNT_W: saturating count of stall cycles.
- `hazard_err` out 1: sticky protocol error.

## Operation
- State: shift register of `WB_LATENCY` entries `{v, rd}`. Stage 0 is the youngest. Stage `WB_LATENCY-1` is writeback and drives `wb_valid`/`wb_rd`.
- Shift every cycle. Stage 0 loads `{1, id_rd}` when `issue && id_reg_write && id_rd != 0`. Otherwise it loads a bubble `{0, 0}`.
- A stage k match occurs when `v[k]`, `rd[k] == id_rsN`, `id_usesN` and `id_rsN != 0` all hold.
- `rsN_hazard` = `id_valid` and a match in any stage. With forwarding, a match only in the writeback stage does not count.
- `raw_hazard` = `rs1_hazard | rs2_hazard`.
- `issue` = `id_valid && !raw_hazard && !flush && !reset`.
- `pc_write` = `!reset && !(id_valid && raw_hazard && !flush)`.
  - `flush` overrides a stall: `pc_write` = 1 and a bubble is inserted.
  - Older in-flight entries are never squashed.
- `id_valid` = 0: `pc_write` = 1, `issue` = 0, bubble inserted.
- `stall_count` increments on every cycle with `id_valid && raw_hazard && !flush`. It saturates at all-ones.
- Run counter: counts consecutive stall cycles and clears on any non-stall cycle. `hazard_err` sets when the run exceeds `WB_LATENCY`, and clears only on reset.
- `fwd_rs1`/`fwd_rs2` are 0 unless forwarding is compiled in.

## Timing
- Reset, checked at the clock edge: all entries invalid, `wb_valid` = 0, `wb_rd` = 0, `stall_count` = 0, run counter = 0, `hazard_err` = 0.
- While `reset` = 1: `pc_write` = 0, `issue` = 0, all hazard and forwarding outputs = 0.
- Reset asserted mid-stall discards all in-flight entries. The first post-reset instruction issues with no stall.
- Combinational from inputs and state: `pc_write`, `issue`, the hazard outputs and `fwd_*`. `wb_valid`, `wb_rd`, `stall_count` and `hazard_err` are registered.
- Producer issued in cycle t occupies stage k during cycle t+1+k and is written back at the end of cycle t+`WB_LATENCY`.
- A dependent instruction immediately following its producer stalls for `WB_LATENCY` cycles, or `WB_LATENCY-1` with forwarding. It issues in the cycle after the last stall.
- Dependency at distance d (producer issued d cycles earlier) stalls `max(0, WB_LATENCY+1-d)` cycles, or one fewer with forwarding, floor 0.
- If the same register is in several stages, any match stalls. Forwarding applies only when the sole match is in writeback.

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - A match found only in the writeback stage is not a hazard.
  - It sets `fwd_rsN` = 1 in the same cycle so the CPU muxes `write_back_data` onto the operand.
  - Run-limit for `hazard_err` stays `WB_LATENCY`.
- Undefined:
  - Every match, including writeback, stalls.
  - `fwd_rs1` and `fwd_rs2` are tied to 0.

## Test plan
- Reset released, independent stream `addi x1`, `addi x2`, `addi x3` with `WB_LATENCY` = 2 -> `pc_write` = 1 every cycle, `stall_count` = 0, `wb_valid` pulses with `wb_rd` = 1, 2, 3 in cycles 3, 4, 5.
- `addi x5` followed by `add x6,x5,x0`, no forwarding -> `rs1_hazard` = 1 and `pc_write` = 0 for 2 cycles, issue on 3rd, `stall_count` = 2. With `HAZARD_FORWARD_EN`: 1 stall cycle, `fwd_rs1` = 1 on the issue cycle.
- Producer writing x0, then consumer reading x0; and a consumer with `id_uses_rs2` = 0 whose `id_rs2` equals a pending rd -> no stall.
- Dependent instruction stalled for 1 cycle, then `flush` = 1 -> `pc_write` = 1, `issue` = 0, bubble inserted, `stall_count` frozen, the producer still reaches writeback.
- Reset asserted during a stall with x7 pending -> next cycle all outputs at reset values. Post-reset `add x8,x7,x7` issues with no stall.
- `stall_count` preloaded near saturation via `STALL_CNT_W` = 2 and 5 stall cycles -> holds at 3. `hazard_err` stays 0 for any legal stream.
